// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   MDUOP_LEN      : width of the MDUOp field
//   mduop_e        : operation codes 0..8 (other codes behave as none)
//   *_CYCLES_DEF   : default latencies of multiply / divide
//   mdu_state_e    : FSM states
//   is_launch()    : true for ops that start a multi-cycle operation
package ex_mdu_pkg;
  localparam int MDUOP_LEN       = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDUOP_LEN-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mduop_e;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;

  function automatic logic is_launch(input logic [MDUOP_LEN-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction
endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/result bundle between the EX stage and the MDU.
//   MDUOp, NumberA, NumberB : driven by the pipeline (master)
//   Busy, HI, LO, MDUResult : driven by the MDU (slave)
interface ex_mdu_if;
  import ex_mdu_pkg::*;

  logic [MDUOP_LEN-1:0] MDUOp;
  logic [31:0]          NumberA;
  logic [31:0]          NumberB;
  logic                 Busy;
  logic [31:0]          HI;
  logic [31:0]          LO;
  logic [31:0]          MDUResult;

  modport master (output MDUOp, NumberA, NumberB,
                  input  Busy, HI, LO, MDUResult);
  modport slave  (input  MDUOp, NumberA, NumberB,
                  output Busy, HI, LO, MDUResult);
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multiply/divide unit owning HI/LO.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   mdu      : ex_mdu_if.slave (MDUOp, NumberA, NumberB in;
//              Busy, HI, LO registered out; MDUResult combinational out)
// The result is computed behaviourally at launch and parked in pHI/pLO;
// Busy then models the fixed latency before it becomes architectural.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset_n,
  ex_mdu_if.slave mdu
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  mdu_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0] phi, plo, hi, lo;
  logic        pdz, busy;

  logic [31:0] a, b, bsafe, nhi, nlo;
  logic [63:0] prod;
  logic        ndz, launch, is_mul;

  assign a      = mdu.NumberA;
  assign b      = mdu.NumberB;
  // Divisor forced non-zero so the operators never see /0; the result is
  // discarded anyway via ndz.
  assign bsafe  = (b == 32'd0) ? 32'd1 : b;
  assign launch = (state == IDLE) && is_launch(mdu.MDUOp);
  assign is_mul = (mdu.MDUOp == MDU_MULT) || (mdu.MDUOp == MDU_MULTU);

  always_comb begin
    prod = 64'd0;
    nhi  = 32'd0;
    nlo  = 32'd0;
    ndz  = 1'b0;
    case (mdu.MDUOp)
      MDU_MULT: begin
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {nhi, nlo} = prod;
      end
      MDU_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        {nhi, nlo} = prod;
      end
      MDU_DIV: begin
        ndz = (b == 32'd0);
        // -2^31 / -1 overflows; pin the wrapped quotient explicitly.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          nlo = 32'h8000_0000;
          nhi = 32'd0;
        end else begin
          nlo = $signed(a) / $signed(bsafe);
          nhi = $signed(a) % $signed(bsafe);
        end
      end
      MDU_DIVU: begin
        ndz = (b == 32'd0);
        nlo = a / bsafe;
        nhi = a % bsafe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      pdz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            phi   <= nhi;
            plo   <= nlo;
            pdz   <= ndz;
            cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy  <= 1'b1;
            state <= RUN;
          end else if (mdu.MDUOp == MDU_MTHI) begin
            hi <= a;
          end else if (mdu.MDUOp == MDU_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          // Anything other than a read arriving here is dropped on purpose.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (!pdz) begin
              hi <= phi;
              lo <= plo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.Busy = busy;
  assign mdu.HI   = hi;
  assign mdu.LO   = lo;

  always_comb begin
    mdu.MDUResult = 32'd0;
    if (mdu.MDUOp == MDU_MFHI)      mdu.MDUResult = hi;
    else if (mdu.MDUOp == MDU_MFLO) mdu.MDUResult = lo;
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  ex_mdu_if m();

  ex_mdu dut (.clk(clk), .reset_n(reset_n), .mdu(m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive op before edge E0, return at E0+1 with the bus back to none.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    m.MDUOp = op; m.NumberA = a; m.NumberB = b;
    @(posedge clk); #1;
    m.MDUOp = MDU_NONE;
  endtask

  // Counts samples (at edge+1) with Busy high; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (m.Busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL busy_timeout: Busy still high after %0d cycles", n);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    m.MDUOp = MDU_NONE; m.NumberA = 32'd0; m.NumberB = 32'd0;
    #12;
    checks++;
    if (m.Busy !== 1'b0 || m.HI !== 32'd0 || m.LO !== 32'd0 || m.MDUResult !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h res=%h, want 0", m.Busy, m.HI, m.LO, m.MDUResult);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_multu;
    int n;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL multu_busy: got %0d want 5", n); end
    checks++;
    if (m.HI !== 32'h1 || m.LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h want 00000001 fffffffe", m.HI, m.LO);
    end
  endtask

  task automatic test_mult;
    int n;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    count_busy(n);
    checks++;
    if (m.HI !== 32'hFFFF_FFFF || m.LO !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff ffffffeb", m.HI, m.LO);
    end
  endtask

  task automatic test_div;
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL div_busy: got %0d want 10", n); end
    checks++;
    if (m.HI !== 32'hFFFF_FFFF || m.LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_result: hi=%h lo=%h want ffffffff fffffffd", m.HI, m.LO);
    end
  endtask

  task automatic test_div_edge;
    int n;
    issue(MDU_DIVU, 32'd7, 32'd0);
    count_busy(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL divz_busy: got %0d want 10", n); end
    checks++;
    if (m.HI !== 32'hFFFF_FFFF || m.LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL divz_keep: hi=%h lo=%h want ffffffff fffffffd", m.HI, m.LO);
    end
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++;
    if (m.HI !== 32'd0 || m.LO !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf: hi=%h lo=%h want 00000000 80000000", m.HI, m.LO);
    end
  endtask

  task automatic test_mthi_ignored;
    int n;
    issue(MDU_MTHI, 32'h1234, 32'd0);
    checks++;
    if (m.HI !== 32'h1234 || m.Busy !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h busy=%b want 00001234 0", m.HI, m.Busy);
    end
    m.MDUOp = MDU_MFLO; #1;
    checks++;
    if (m.MDUResult !== 32'h8000_0000) begin
      errors++; $display("FAIL mflo: got %h want 80000000", m.MDUResult);
    end
    m.MDUOp = MDU_MFHI; #1;
    checks++;
    if (m.MDUResult !== 32'h1234) begin
      errors++; $display("FAIL mfhi: got %h want 00001234", m.MDUResult);
    end
    m.MDUOp = 4'd13; #1;
    checks++;
    if (m.MDUResult !== 32'd0) begin
      errors++; $display("FAIL undef_op: got %h want 0", m.MDUResult);
    end
    m.MDUOp = MDU_NONE;
    issue(MDU_MULT, 32'd3, 32'd5);
    issue(MDU_MULT, 32'd100, 32'd100);   // must be dropped
    issue(MDU_MTHI, 32'hDEAD, 32'd0);    // must be dropped
    m.MDUOp = MDU_MFHI; #1;
    checks++;
    if (m.MDUResult !== 32'h1234) begin
      errors++; $display("FAIL mfhi_busy: got %h want 00001234", m.MDUResult);
    end
    m.MDUOp = MDU_NONE;
    count_busy(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL ignored_busy: got %0d want 3", n); end
    checks++;
    if (m.HI !== 32'd0 || m.LO !== 32'd15) begin
      errors++; $display("FAIL ignored_result: hi=%h lo=%h want 00000000 0000000f", m.HI, m.LO);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(MDU_MULTU, 32'd6, 32'd7);
    count_busy(n);
    // count_busy returns at E(N)+1, so this launch lands on E(N+1)
    issue(MDU_DIVU, 32'd100, 32'd7);
    checks++;
    if (m.LO !== 32'd42 || m.HI !== 32'd0 || m.Busy !== 1'b1) begin
      errors++; $display("FAIL b2b_first: hi=%h lo=%h busy=%b want 0 0000002a 1", m.HI, m.LO, m.Busy);
    end
    count_busy(n);
    checks++;
    if (n !== 10 || m.LO !== 32'd14 || m.HI !== 32'd2) begin
      errors++; $display("FAIL b2b_second: n=%0d hi=%h lo=%h want 10 00000002 0000000e", n, m.HI, m.LO);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b0; #1;
    checks++;
    if (m.Busy !== 1'b0 || m.HI !== 32'd0 || m.LO !== 32'd0) begin
      errors++; $display("FAIL mid_reset: busy=%b hi=%h lo=%h want 0", m.Busy, m.HI, m.LO);
    end
    #4;
    reset_n = 1'b1;
    m.MDUOp = MDU_MULTU; m.NumberA = 32'd3; m.NumberB = 32'd4;
    @(posedge clk); #1;
    m.MDUOp = MDU_NONE;
    checks++;
    if (m.Busy !== 1'b1) begin errors++; $display("FAIL post_reset_launch: busy=%b want 1", m.Busy); end
    count_busy(n);
    checks++;
    if (n !== 5 || m.LO !== 32'd12 || m.HI !== 32'd0) begin
      errors++; $display("FAIL post_reset_result: n=%0d hi=%h lo=%h want 5 0 0000000c", n, m.HI, m.LO);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_edge();
    test_mthi_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
